// File: rtl/prog_seq_pkg.sv
`default_nettype none
// =====================================================================
// prog_seq_pkg : shared types and constants for the program sequencer
// Rev 1.0
// =====================================================================
package prog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic BR_REL = 1'b0;
    localparam logic BR_ABS = 1'b1;

    // Entry points of the resident programs: int2float, float2int, fixed-point mult
    localparam int NPROG_TBL = 3;
    localparam int PROG_BASE [NPROG_TBL] = '{0, 256, 512};

    function automatic int prog_base(input int idx);
        if (idx >= 0 && idx < NPROG_TBL) begin
            return PROG_BASE[idx];
        end
        return 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_sequencer_pc_next_calc.sv
`default_nettype none
// =====================================================================
// pc_next_calc : combinational next-PC selection and wrap detection
// Rev 1.0
// =====================================================================
module pc_next_calc
    import prog_seq_pkg::*;
#(
    parameter int PCW = 10
) (
    input  logic [PCW-1:0] pc,
    input  logic           stall,
    input  logic           halt,
    input  logic           branch_en,
    input  logic           branch_type,
    input  logic           cmp_flag,
    input  logic [PCW-1:0] branch_target,
    output logic [PCW-1:0] next_pc,
    output logic           wrap_event
);

    // Two guard bits catch both carry-out and borrow of the signed relative add
    logic [PCW+1:0] w_rel_sum;
    assign w_rel_sum = {2'b00, pc} + {{2{branch_target[PCW-1]}}, branch_target};

    always_comb begin
        next_pc    = pc;
        wrap_event = 1'b0;
        if (stall || halt) begin
            next_pc    = pc;
        end else if (branch_en && cmp_flag) begin
            if (branch_type == BR_ABS) begin
                next_pc = branch_target;
            end else begin
                next_pc    = w_rel_sum[PCW-1:0];
                wrap_event = (w_rel_sum[PCW+1:PCW] != 2'b00);
            end
        end else begin
            next_pc    = pc + PCW'(1);
            wrap_event = &pc;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// =====================================================================
// prog_sequencer : fetch/run controller with program select and start/done
// Rev 1.0
// =====================================================================
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PCW   = 10,
    parameter int NPROG = 3,
    parameter int PSW   = 2,
    parameter int CCW   = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [PSW-1:0] prog_sel,
    input  logic           stall,
    input  logic           halt,
    input  logic           branch_en,
    input  logic           branch_type,
    input  logic           cmp_flag,
    input  logic [PCW-1:0] branch_target,
    output logic [PCW-1:0] pc,
    output logic           running,
    output logic           done,
    output logic [CCW-1:0] cycle_count,
    output logic           pc_wrap,
    output logic           bad_prog
);

    state_t         r_state;
    logic [PCW-1:0] r_pc;
    logic           r_running;
    logic           r_done;
    logic [CCW-1:0] r_cycle_count;
    logic           r_pc_wrap;
    logic           r_bad_prog;

    logic [PCW-1:0] w_next_pc;
    logic           w_wrap_event;
    logic           w_sel_ok;

    assign w_sel_ok = int'(prog_sel) < NPROG;

    pc_next_calc #(
        .PCW(PCW)
    ) u_pc_next_calc (
        .pc            (r_pc),
        .stall         (stall),
        .halt          (halt),
        .branch_en     (branch_en),
        .branch_type   (branch_type),
        .cmp_flag      (cmp_flag),
        .branch_target (branch_target),
        .next_pc       (w_next_pc),
        .wrap_event    (w_wrap_event)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_cycle_count <= '0;
            r_pc_wrap     <= 1'b0;
            r_bad_prog    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        if (w_sel_ok) begin
                            r_state       <= ST_RUN;
                            r_pc          <= PCW'(prog_base(int'(prog_sel)));
                            r_running     <= 1'b1;
                            r_done        <= 1'b0;
                            r_cycle_count <= '0;
                            r_pc_wrap     <= 1'b0;
                            r_bad_prog    <= 1'b0;
                        end else begin
                            r_bad_prog    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_pc <= w_next_pc;
                    if (w_wrap_event) begin
                        r_pc_wrap <= 1'b1;
                    end
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + CCW'(1);
                    end
                    // Stall masks halt so a multicycle access completes first
                    if (!stall && halt) begin
                        r_state   <= ST_HALTED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign running     = r_running;
    assign done        = r_done;
    assign cycle_count = r_cycle_count;
    assign pc_wrap     = r_pc_wrap;
    assign bad_prog    = r_bad_prog;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// =====================================================================
// tb_prog_sequencer : scoreboard bench, directed plan plus random traffic
// Rev 1.0
// =====================================================================
module tb_prog_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stall, halt, branch_en, branch_type, cmp_flag;
    logic [1:0] prog_sel;
    logic [9:0] branch_target;

    logic [9:0]  pc_a, pc_b;
    logic        running_a, running_b, done_a, done_b;
    logic        pc_wrap_a, pc_wrap_b, bad_prog_a, bad_prog_b;
    logic [15:0] cc_a;
    logic [3:0]  cc_b;

    always #5 clk = ~clk;

    prog_sequencer #(.PCW(10), .NPROG(3), .PSW(2), .CCW(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .stall(stall), .halt(halt), .branch_en(branch_en),
        .branch_type(branch_type), .cmp_flag(cmp_flag),
        .branch_target(branch_target), .pc(pc_a), .running(running_a),
        .done(done_a), .cycle_count(cc_a), .pc_wrap(pc_wrap_a),
        .bad_prog(bad_prog_a)
    );

    prog_sequencer #(.PCW(10), .NPROG(3), .PSW(2), .CCW(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel),
        .stall(stall), .halt(halt), .branch_en(branch_en),
        .branch_type(branch_type), .cmp_flag(cmp_flag),
        .branch_target(branch_target), .pc(pc_b), .running(running_b),
        .done(done_b), .cycle_count(cc_b), .pc_wrap(pc_wrap_b),
        .bad_prog(bad_prog_b)
    );

    typedef struct {
        int pc;
        bit running;
        bit done;
        int cc;
        bit wrap;
        bit bad;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0 idle, 1 running a program, 2 finished
    int m_mode = 0, m_pc = 0, m_cc = 0;
    bit m_run = 0, m_done = 0, m_wrap = 0, m_bad = 0;
    int base_tbl [3] = '{0, 256, 512};

    task automatic model_step(input bit r, st, input int sel, input bit sl, hl, be, bt, cf, input int tgt);
        int off, n;
        if (r) begin
            m_mode = 0; m_pc = 0; m_cc = 0;
            m_run = 0; m_done = 0; m_wrap = 0; m_bad = 0;
        end else if (m_mode != 1) begin
            if (st && sel < 3) begin
                m_mode = 1; m_pc = base_tbl[sel]; m_cc = 0;
                m_run = 1; m_done = 0; m_wrap = 0; m_bad = 0;
            end else if (st) begin
                m_bad = 1;
            end
        end else begin
            m_cc = m_cc + 1;
            if (sl) begin
                // pc frozen
            end else if (hl) begin
                m_mode = 2; m_run = 0; m_done = 1;
            end else if (be && cf) begin
                if (bt) begin
                    m_pc = tgt;
                end else begin
                    off = (tgt >= 512) ? tgt - 1024 : tgt;
                    n = m_pc + off;
                    if (n < 0 || n > 1023) m_wrap = 1;
                    m_pc = (n + 1024) % 1024;
                end
            end else begin
                n = m_pc + 1;
                if (n == 1024) m_wrap = 1;
                m_pc = n % 1024;
            end
        end
    endtask

    task automatic cyc(input bit r, st, input int sel, input bit sl, hl, be, bt, cf, input int tgt);
        exp_t e;
        @(negedge clk);
        reset = r; start = st; prog_sel = 2'(sel); stall = sl; halt = hl;
        branch_en = be; branch_type = bt; cmp_flag = cf; branch_target = 10'(tgt);
        model_step(r, st, sel, sl, hl, be, bt, cf, tgt);
        e.pc = m_pc; e.running = m_run; e.done = m_done;
        e.cc = m_cc; e.wrap = m_wrap; e.bad = m_bad;
        q.push_back(e);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares each registered output set just after the edge
    initial begin
        exp_t e;
        int   c16, c4;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e   = q.pop_front();
                c16 = (e.cc > 65535) ? 65535 : e.cc;
                c4  = (e.cc > 15) ? 15 : e.cc;
                total++;
                if (int'(pc_a) != e.pc || running_a != e.running || done_a != e.done ||
                    int'(cc_a) != c16 || pc_wrap_a != e.wrap || bad_prog_a != e.bad) begin
                    bad++;
                    $display("FAIL ccw16 t=%0t got pc=%0d run=%0b done=%0b cc=%0d wrap=%0b bad=%0b want pc=%0d run=%0b done=%0b cc=%0d wrap=%0b bad=%0b",
                             $time, pc_a, running_a, done_a, cc_a, pc_wrap_a, bad_prog_a,
                             e.pc, e.running, e.done, c16, e.wrap, e.bad);
                end
                total++;
                if (int'(pc_b) != e.pc || running_b != e.running || done_b != e.done ||
                    int'(cc_b) != c4 || pc_wrap_b != e.wrap || bad_prog_b != e.bad) begin
                    bad++;
                    $display("FAIL ccw4 t=%0t got pc=%0d run=%0b done=%0b cc=%0d wrap=%0b bad=%0b want pc=%0d run=%0b done=%0b cc=%0d wrap=%0b bad=%0b",
                             $time, pc_b, running_b, done_b, cc_b, pc_wrap_b, bad_prog_b,
                             e.pc, e.running, e.done, c4, e.wrap, e.bad);
                end
            end
        end
    end

    initial begin
        reset = 1; start = 0; prog_sel = 0; stall = 0; halt = 0;
        branch_en = 0; branch_type = 0; cmp_flag = 0; branch_target = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Program 1 from 256, four sequential steps
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        nop(4);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 'h3FD);   // not taken
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 'h3FD);   // relative -3
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 'h005);   // absolute to 5
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 300);
        // Stall masks halt and branch for three cycles
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 1, 1, 1, 7);
        cyc(0, 0, 0, 0, 1, 1, 1, 1, 7);       // halt beats branch
        nop(2);
        // Program 2, jump near top, wrap on sequential steps
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 1022);
        nop(3);
        cyc(0, 0, 0, 0, 0, 1, 0, 1, 'h3FC);   // relative borrow below 0
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);       // restart clears wrap/done
        nop(20);                              // saturates the 4-bit counter
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 3, 0, 0, 0, 0, 0, 0);       // invalid selection
        nop(2);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 1, 270);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);       // abort mid-run
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(2);
        cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);       // ignored while running
        nop(2);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(199) == 0, $urandom_range(99) < 6, int'($urandom_range(3)),
                $urandom_range(99) < 15, $urandom_range(99) < 4,
                $urandom_range(99) < 30, $urandom_range(1) == 1,
                $urandom_range(1) == 1, int'($urandom_range(1023)));
        end

        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
